// File: rtl/axis_waypoint_ctrl_if.sv
// ============================================================================
// Module   : axis_waypoint_ctrl_if
// Purpose  : Waypoint push channel (valid/data/ready) for axis_waypoint_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface axis_waypoint_ctrl_if #(
    parameter int AXES = 2,
    parameter int W    = 4
);
    logic                wp_valid;
    logic [AXES*W-1:0]   wp_data;
    logic                wp_ready;

    modport master (output wp_valid, output wp_data, input  wp_ready);
    modport slave  (input  wp_valid, input  wp_data, output wp_ready);
endinterface

`default_nettype wire

// File: rtl/axis_waypoint_ctrl.sv
// ============================================================================
// Module   : axis_waypoint_ctrl
// Purpose  : Multi-axis positioner with a waypoint FIFO, programmable step
//            rate and diagonal/sequential motion. Optional macro WP_LIMIT_EN
//            adds a coordinate limit check with a sticky err_reject flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axis_waypoint_ctrl #(
    parameter int AXES     = 2,
    parameter int W        = 4,
    parameter int DEPTH    = 4,
    parameter int STEP_DIV = 1
`ifdef WP_LIMIT_EN
    ,
    parameter int LIMIT    = (1 << W) - 1
`endif
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    axis_waypoint_ctrl_if.slave               wp,
    input  wire logic                         motion,
    input  wire logic                         mode_diag,
    input  wire logic                         home,
    output logic [AXES*W-1:0]                 pos,
    output logic [AXES-1:0]                   step,
    output logic [AXES-1:0]                   dir,
    output logic                              busy,
    output logic                              arrived,
    output logic [$clog2(DEPTH+1)-1:0]        wp_count
`ifdef WP_LIMIT_EN
    ,
    output logic                              err_reject
`endif
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_dw = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_dw-1:0] c_div_max = c_dw'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_MOVE   = 2'd2,
        S_ARRIVE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Waypoint FIFO
    // ------------------------------------------------------------------
    logic [AXES*W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_coord_ok;
    logic              w_push;
    logic              w_pop;

    state_t            r_state;

    assign w_full      = (r_count == c_cw'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign wp.wp_ready = !w_full;
    assign wp_count    = r_count;

`ifdef WP_LIMIT_EN
    localparam logic [31:0] c_limit = LIMIT;

    always_comb begin
        w_coord_ok = 1'b1;
        for (int i = 0; i < AXES; i++) begin
            if (32'(wp.wp_data[i*W +: W]) > c_limit) begin
                w_coord_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || home) begin
            err_reject <= 1'b0;
        end else if (wp.wp_valid && !w_full && !w_coord_ok) begin
            err_reject <= 1'b1;
        end
    end
`else
    assign w_coord_ok = 1'b1;
`endif

    // home drops a concurrent push because its branch below wins over the FIFO update.
    assign w_push = wp.wp_valid && !w_full && w_coord_ok;
    assign w_pop  = (r_state == S_IDLE) && motion && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wp.wp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || home) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Motion control
    // ------------------------------------------------------------------
    logic [AXES*W-1:0] r_pos;
    logic [AXES*W-1:0] r_tgt;
    logic [AXES-1:0]   r_step;
    logic [AXES-1:0]   r_dir;
    logic [c_dw-1:0]   r_div;
    logic              r_mode_diag;
    logic              r_busy;
    logic              r_arrived;

    logic [AXES-1:0]   w_diff;
    logic [AXES-1:0]   w_up;
    logic [AXES-1:0]   w_sel;

    for (genvar g = 0; g < AXES; g++) begin : g_axis
        assign w_diff[g] = (r_pos[g*W +: W] != r_tgt[g*W +: W]);
        assign w_up[g]   = (r_tgt[g*W +: W] >  r_pos[g*W +: W]);
    end

    // Sequential mode isolates the lowest-index axis still off target.
    assign w_sel = r_mode_diag ? w_diff : (w_diff & (~w_diff + AXES'(1)));

    always_ff @(posedge clk) begin
        if (reset || home) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_tgt       <= '0;
            r_step      <= '0;
            r_dir       <= '0;
            r_div       <= '0;
            r_mode_diag <= 1'b0;
            r_busy      <= 1'b0;
            r_arrived   <= 1'b0;
        end else begin
            r_step    <= '0;
            r_arrived <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tgt       <= r_mem[r_rd_ptr];
                        r_mode_diag <= mode_diag;
                        r_div       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_MOVE;
                end
                S_MOVE: begin
                    if (w_diff == '0) begin
                        r_arrived <= 1'b1;
                        r_state   <= S_ARRIVE;
                    end else if (motion) begin
                        if (r_div == c_div_max) begin
                            r_div  <= '0;
                            r_step <= w_sel;
                            for (int i = 0; i < AXES; i++) begin
                                if (w_sel[i]) begin
                                    r_dir[i] <= w_up[i];
                                    r_pos[i*W +: W] <= w_up[i] ? r_pos[i*W +: W] + W'(1)
                                                               : r_pos[i*W +: W] - W'(1);
                                end
                            end
                        end else begin
                            r_div <= r_div + c_dw'(1);
                        end
                    end
                end
                S_ARRIVE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pos     = r_pos;
    assign step    = r_step;
    assign dir     = r_dir;
    assign busy    = r_busy;
    assign arrived = r_arrived;

endmodule

`default_nettype wire

// File: tb/tb_axis_waypoint_ctrl.sv
// ============================================================================
// Module   : tb_axis_waypoint_ctrl
// Purpose  : Directed scoreboard bench for axis_waypoint_ctrl (2 axes, W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_waypoint_ctrl;

    localparam int AXES     = 2;
    localparam int W        = 4;
    localparam int DEPTH    = 4;
    localparam int STEP_DIV = 3;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          motion    = 1'b0;
    logic          mode_diag = 1'b0;
    logic          home      = 1'b0;
    logic [7:0]    pos;
    logic [1:0]    step;
    logic [1:0]    dir;
    logic          busy;
    logic          arrived;
    logic [CW-1:0] wp_count;
`ifdef WP_LIMIT_EN
    logic          err_reject;
`endif

    axis_waypoint_ctrl_if #(.AXES(AXES), .W(W)) wp_if ();

    axis_waypoint_ctrl #(
        .AXES(AXES), .W(W), .DEPTH(DEPTH), .STEP_DIV(STEP_DIV)
`ifdef WP_LIMIT_EN
        , .LIMIT(9)
`endif
    ) dut (
        .clk(clk), .reset(reset), .wp(wp_if), .motion(motion),
        .mode_diag(mode_diag), .home(home), .pos(pos), .step(step),
        .dir(dir), .busy(busy), .arrived(arrived), .wp_count(wp_count)
`ifdef WP_LIMIT_EN
        , .err_reject(err_reject)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] pos; logic [1:0] step; logic [1:0] dir; bit first; } step_t;
    typedef struct { logic [7:0] pos; int nsteps; } arr_t;

    step_t      sq[$];
    arr_t       aq[$];
    int         checks = 0;
    int         errors = 0;
    int         steps_seen = 0;
    int         arrivals = 0;
    int         mcyc = 0;
    int         last_tick = 0;
    logic [7:0] tail;
    step_t      m_e;
    arr_t       m_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference walk from the queue tail to tgt, one entry per tick.
    task automatic model_wp(input logic [7:0] tgt, input bit diag);
        logic [3:0] c0, c1, t0, t1;
        logic [1:0] m, d;
        step_t e;
        int  n;
        bit  first;
        c0 = tail[3:0]; c1 = tail[7:4];
        t0 = tgt[3:0];  t1 = tgt[7:4];
        n = 0; first = 1'b1;
        while (c0 != t0 || c1 != t1) begin
            m = 2'b00; d = 2'b00;
            if (c0 != t0) begin
                m[0] = 1'b1; d[0] = (t0 > c0);
                c0 = d[0] ? c0 + 4'd1 : c0 - 4'd1;
            end
            if (c1 != t1 && (diag || m == 2'b00)) begin
                m[1] = 1'b1; d[1] = (t1 > c1);
                c1 = d[1] ? c1 + 4'd1 : c1 - 4'd1;
            end
            e.pos = {c1, c0}; e.step = m; e.dir = d; e.first = first;
            sq.push_back(e);
            first = 1'b0;
            n++;
        end
        aq.push_back('{pos: tgt, nsteps: n});
        tail = tgt;
    endtask

    task automatic push(input logic [3:0] x, input logic [3:0] y, input bit store);
        @(negedge clk);
        wp_if.wp_valid = 1'b1;
        wp_if.wp_data  = {y, x};
        if (store) model_wp({y, x}, mode_diag);
        @(negedge clk);
        wp_if.wp_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int  n;
        bit  timed_out;
        n = 0;
        while ((sq.size() != 0 || aq.size() != 0 || busy !== 1'b0 || wp_count !== '0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= maxc);
        chk("wait_done_timeout", 32'(timed_out), 0);
    endtask

    // Clears through home or reset, with a push attempted in the same cycle.
    task automatic clear_pulse(input bit use_reset);
        @(negedge clk);
        if (use_reset) reset = 1'b1; else home = 1'b1;
        wp_if.wp_valid = 1'b1;
        wp_if.wp_data  = 8'h55;
        sq.delete();
        aq.delete();
        steps_seen = 0;
        tail = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        home  = 1'b0;
        wp_if.wp_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (motion) mcyc++;
        if (step !== 2'b00) begin
            if (sq.size() == 0) begin
                chk("step_unexpected", 32'(step), 0);
            end else begin
                m_e = sq.pop_front();
                chk("step_pos", 32'(pos), 32'(m_e.pos));
                chk("step_mask", 32'(step), 32'(m_e.step));
                chk("step_dir", 32'(dir & step), 32'(m_e.dir & m_e.step));
                if (!m_e.first) chk("tick_spacing", mcyc - last_tick, STEP_DIV);
                last_tick = mcyc;
                steps_seen++;
            end
        end
        if (arrived === 1'b1) begin
            if (aq.size() == 0) begin
                chk("arrived_unexpected", 32'(arrived), 0);
            end else begin
                m_a = aq.pop_front();
                chk("arrive_pos", 32'(pos), 32'(m_a.pos));
                chk("arrive_nsteps", steps_seen, m_a.nsteps);
                chk("arrive_busy", 32'(busy), 1);
                steps_seen = 0;
                arrivals++;
            end
        end
    end

    initial begin
        int         a0;
        int         n;
        int         s_before;
        logic [7:0] frozen;

        wp_if.wp_valid = 1'b0;
        wp_if.wp_data  = '0;
        tail = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_count", 32'(wp_count), 0);
        chk("rst_ready", 32'(wp_if.wp_ready), 1);
        chk("rst_step", 32'(step), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_arrived", 32'(arrived), 0);
        reset = 1'b0;

        // Diagonal move from origin
        mode_diag = 1'b1; motion = 1'b1;
        push(4'd3, 4'd2, 1'b1);
        wait_done(100);
        chk("diag_final_pos", 32'(pos), 32'h23);
        chk("diag_busy_low", 32'(busy), 0);

        // Sequential move
        mode_diag = 1'b0;
        push(4'd0, 4'd5, 1'b1);
        wait_done(200);
        chk("seq_final_pos", 32'(pos), 32'h50);

        // Queue fill while paused, including a zero-distance entry and range extremes
        motion = 1'b0; mode_diag = 1'b1; a0 = arrivals;
        push(4'd1,  4'd1,  1'b1); chk("q_count1", 32'(wp_count), 1);
        push(4'd1,  4'd1,  1'b1); chk("q_count2", 32'(wp_count), 2);
        push(4'd15, 4'd15, 1'b1); chk("q_count3", 32'(wp_count), 3);
        push(4'd0,  4'd15, 1'b1); chk("q_count4", 32'(wp_count), 4);
        chk("q_ready_full", 32'(wp_if.wp_ready), 0);
        push(4'd7,  4'd7,  1'b0); chk("q_push_full_ignored", 32'(wp_count), 4);
        motion = 1'b1;
        wait_done(400);
        chk("q_arrivals", arrivals - a0, 4);
        chk("q_final_pos", 32'(pos), 32'hF0);

        // Pause mid-move
        push(4'd6, 4'd9, 1'b1);
        n = 0;
        while (steps_seen < 2 && n < 100) begin @(negedge clk); n++; end
        chk("pause_reach_timeout", 32'(n >= 100), 0);
        motion = 1'b0; frozen = pos; s_before = sq.size();
        repeat (5) begin
            @(negedge clk);
            chk("pause_pos", 32'(pos), 32'(frozen));
            chk("pause_step", 32'(step), 0);
        end
        chk("pause_remaining", sq.size(), s_before);
        motion = 1'b1;
        wait_done(200);
        chk("pause_final_pos", 32'(pos), 32'h96);

        // home then reset mid-move, each with two queued waypoints
        for (int k = 0; k < 2; k++) begin
            clear_pulse(1'b0);
            motion = 1'b0; mode_diag = 1'b1;
            push(4'd3, 4'd1, 1'b1);
            push(4'd1, 4'd1, 1'b1);
            @(negedge clk);
            motion = 1'b1;
            wp_if.wp_valid = 1'b1;
            wp_if.wp_data  = 8'h22;
            model_wp(8'h22, 1'b1);
            @(negedge clk);
            wp_if.wp_valid = 1'b0;
            chk("push_pop_count", 32'(wp_count), 2);
            n = 0;
            while (pos !== 8'h12 && n < 100) begin @(negedge clk); n++; end
            chk("mid_move_timeout", 32'(n >= 100), 0);
            a0 = arrivals;
            clear_pulse(k == 1);
            chk("clr_pos", 32'(pos), 0);
            chk("clr_count", 32'(wp_count), 0);
            chk("clr_busy", 32'(busy), 0);
            chk("clr_arrived", 32'(arrived), 0);
            chk("clr_ready", 32'(wp_if.wp_ready), 1);
            repeat (10) @(negedge clk);
            chk("clr_no_arrival", arrivals - a0, 0);
            chk("clr_pos_hold", 32'(pos), 0);
        end

`ifdef WP_LIMIT_EN
        motion = 1'b0;
        push(4'd10, 4'd0, 1'b0);
        chk("lim_reject_count", 32'(wp_count), 0);
        chk("lim_err_set", 32'(err_reject), 1);
        push(4'd9, 4'd9, 1'b0);
        chk("lim_accept_count", 32'(wp_count), 1);
        clear_pulse(1'b0);
        chk("lim_err_cleared", 32'(err_reject), 0);
        chk("lim_count_cleared", 32'(wp_count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

`default_nettype wire
